// File: rtl/bus_pkg.sv
// Shared types and constants for the bus transfer sequencer and its request FIFO.
package bus_pkg;
  localparam int FIFO_DEPTH = 2;
  localparam int ENTRY_W    = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    LOAD   = 2'd2,
    FINISH = 2'd3
  } seq_state_t;

  function automatic logic [3:0] dst_onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction
endpackage

// File: rtl/req_fifo2.sv
// Two-entry request FIFO. The consumer sees a freshly pushed entry one cycle
// after it lands, so the head has a full cycle to settle before it is used.
module req_fifo2
  import bus_pkg::*;
#(
  parameter int width = ENTRY_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [width-1:0] wdata,
  input  logic             pop,
  output logic [width-1:0] rdata,
  output logic             full,
  output logic             valid
);
  logic [width-1:0] mem [FIFO_DEPTH];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic             avail_q;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && (count != 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count   <= 2'd0;
      avail_q <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      avail_q <= (count != 2'd0);
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == 2'(FIFO_DEPTH));
  assign valid = avail_q;
endmodule

// File: rtl/bus_transfer_sequencer.sv
// Sequences queued register-to-register transfers over a 4:1 bus mux:
// selects the source, pulses the destination load, then reports completion.
//
// state  | meaning
// IDLE   | waiting for a queued request; mux select holds last source
// SELECT | mux select driven from popped source, bus settling
// LOAD   | destination load pulse (unless src==dst), bus value captured
// FINISH | done pulse, nop qualifier, transfer counter advanced
module bus_transfer_sequencer
  import bus_pkg::*;
#(
  parameter int size = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req,
  input  logic [1:0]      src,
  input  logic [1:0]      dst,
  output logic            ready,
  input  logic [size-1:0] bus_in,
  output logic            s0,
  output logic            s1,
  output logic [3:0]      ld,
  output logic [size-1:0] xfer_data,
  output logic            done,
  output logic            nop,
  output logic [7:0]      xfer_cnt
);
  seq_state_t         state_q, state_d;
  logic [ENTRY_W-1:0] head;
  logic               fifo_full;
  logic               fifo_valid;
  logic               push;
  logic               pop;
  logic [1:0]         cur_src_q;
  logic [1:0]         cur_dst_q;
  logic [3:0]         ld_q, ld_d;
  logic               done_q, done_d;
  logic               nop_q, nop_d;
  logic               capture;
  logic [size-1:0]    xfer_data_q;
  logic [7:0]         cnt_q;

  assign push = req && !fifo_full;
  assign pop  = (state_q == IDLE) && fifo_valid;

  req_fifo2 #(.width(ENTRY_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata ({src, dst}),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .valid (fifo_valid)
  );

  // Output registers are loaded one state early so they are valid throughout the target state.
  always_comb begin
    state_d = state_q;
    ld_d    = 4'b0000;
    done_d  = 1'b0;
    nop_d   = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE:   if (fifo_valid) state_d = SELECT;
      SELECT: begin
        state_d = LOAD;
        if (cur_src_q != cur_dst_q) ld_d = dst_onehot(cur_dst_q);
      end
      LOAD: begin
        state_d = FINISH;
        capture = 1'b1;
        done_d  = 1'b1;
        nop_d   = (cur_src_q == cur_dst_q);
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cur_src_q   <= 2'd0;
      cur_dst_q   <= 2'd0;
      ld_q        <= 4'b0000;
      done_q      <= 1'b0;
      nop_q       <= 1'b0;
      xfer_data_q <= '0;
      cnt_q       <= 8'd0;
    end else begin
      state_q <= state_d;
      ld_q    <= ld_d;
      done_q  <= done_d;
      nop_q   <= nop_d;
      if (pop) begin
        cur_src_q <= head[3:2];
        cur_dst_q <= head[1:0];
      end
      if (capture) begin
        xfer_data_q <= bus_in;
        cnt_q       <= cnt_q + 8'd1;
      end
    end
  end

  assign ready     = !fifo_full;
  assign s1        = cur_src_q[1];
  assign s0        = cur_src_q[0];
  assign ld        = ld_q;
  assign done      = done_q;
  assign nop       = nop_q;
  assign xfer_data = xfer_data_q;
  assign xfer_cnt  = cnt_q;
endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// Self-checking bench: directed scenarios plus random traffic against a
// transfer-scheduling reference model.
module tb_bus_transfer_sequencer;
  localparam int SIZE = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            req;
  logic [1:0]      src;
  logic [1:0]      dst;
  logic            ready;
  logic [SIZE-1:0] bus_in;
  logic            s0;
  logic            s1;
  logic [3:0]      ld;
  logic [SIZE-1:0] xfer_data;
  logic            done;
  logic            nop;
  logic [7:0]      xfer_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bus_transfer_sequencer #(.size(SIZE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .src       (src),
    .dst       (dst),
    .ready     (ready),
    .bus_in    (bus_in),
    .s0        (s0),
    .s1        (s1),
    .ld        (ld),
    .xfer_data (xfer_data),
    .done      (done),
    .nop       (nop),
    .xfer_cnt  (xfer_cnt)
  );

  // Reference model: queued requests, each served in a 4-cycle slot. An entry
  // can start two edges after it was pushed; done comes two edges after start.
  typedef struct {
    logic [1:0] s;
    logic [1:0] d;
    int         pushed;
  } ent_t;

  ent_t        mq[$];
  ent_t        act;
  int          edge_no     = 0;
  int          pop_edge    = -100;
  int          next_pop_ok = 0;
  bit          have_act    = 0;
  bit          accepted    = 0;
  logic [1:0]  m_sel       = 2'd0;
  logic [7:0]  m_cnt       = 8'd0;
  logic [31:0] m_data      = 32'd0;
  int          done_total  = 0;
  bit          rec_on      = 0;
  logic [3:0]  ldseq[$];
  int          dedges[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit acc;
    bit pop_now;
    edge_no++;
    acc     = req && (mq.size() < 2);
    pop_now = (mq.size() > 0) && (mq[0].pushed <= edge_no - 2) && (edge_no >= next_pop_ok);
    if (have_act && edge_no == pop_edge + 2) begin
      m_cnt  = m_cnt + 8'd1;
      m_data = bus_in;
    end
    if (pop_now) begin
      act         = mq.pop_front();
      pop_edge    = edge_no;
      next_pop_ok = edge_no + 4;
      m_sel       = act.s;
      have_act    = 1;
    end
    if (acc) mq.push_back(ent_t'{src, dst, edge_no});
    accepted = acc;
  endtask

  task automatic check_all();
    logic [3:0] eld;
    logic       edone;
    logic       enop;
    edone = have_act && (edge_no == pop_edge + 2);
    enop  = edone && (act.s == act.d);
    eld   = (have_act && edge_no == pop_edge + 1 && act.s != act.d) ? (4'b0001 << act.d) : 4'b0000;
    chk("ready", 64'(ready), 64'(mq.size() < 2));
    chk("sel", 64'({s1, s0}), 64'(m_sel));
    chk("ld", 64'(ld), 64'(eld));
    chk("done", 64'(done), 64'(edone));
    chk("nop", 64'(nop), 64'(enop));
    chk("xfer_cnt", 64'(xfer_cnt), 64'(m_cnt));
    chk("xfer_data", 64'(xfer_data), 64'(m_data));
  endtask

  task automatic step(input logic r, input logic [1:0] s, input logic [1:0] d, input logic [31:0] b);
    req = r; src = s; dst = d; bus_in = b;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
    if (done === 1'b1) done_total++;
    if (rec_on) begin
      if (ld !== 4'b0000) ldseq.push_back(ld);
      if (done === 1'b1) dedges.push_back(edge_no);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'd0, 2'd0, $urandom());
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 1'b0;
    #1;
    chk("rst_ready", 64'(ready), 64'(1));
    chk("rst_sel", 64'({s1, s0}), 64'(0));
    chk("rst_ld", 64'(ld), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_nop", 64'(nop), 64'(0));
    chk("rst_data", 64'(xfer_data), 64'(0));
    chk("rst_cnt", 64'(xfer_cnt), 64'(0));
    mq.delete();
    have_act = 0; next_pop_ok = 0; pop_edge = -100;
    m_sel = 2'd0; m_cnt = 8'd0; m_data = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic rand_traffic(input int n);
    bit         hold = 0;
    logic [1:0] hs = 2'd0;
    logic [1:0] hd = 2'd0;
    for (int i = 0; i < n; i++) begin
      if (!hold && ($urandom_range(0, 99) < 60)) begin
        hold = 1;
        hs   = 2'($urandom_range(0, 3));
        hd   = 2'($urandom_range(0, 3));
      end
      step(hold, hs, hd, $urandom());
      if (accepted) hold = 0;
    end
  endtask

  initial begin
    int k;
    rst_n = 1'b0; req = 1'b0; src = 2'd0; dst = 2'd0; bus_in = '0;
    @(negedge clk);
    do_reset();

    // Single transfer 2 -> 1, latency and captured value
    step(1'b1, 2'd2, 2'd1, 32'hDEADBEEF);
    step(1'b0, 2'd0, 2'd0, 32'hDEADBEEF);
    step(1'b0, 2'd0, 2'd0, 32'hDEADBEEF);
    chk("t034_sel", 64'({s1, s0}), 64'(2'b10));
    step(1'b0, 2'd0, 2'd0, 32'hDEADBEEF);
    chk("t034_ld", 64'(ld), 64'(4'b0010));
    step(1'b0, 2'd0, 2'd0, 32'hDEADBEEF);
    chk("t034_done", 64'(done), 64'(1));
    chk("t034_data", 64'(xfer_data), 64'(32'hDEADBEEF));
    chk("t034_cnt", 64'(xfer_cnt), 64'(1));
    step(1'b0, 2'd0, 2'd0, $urandom());
    chk("t034_done_end", 64'(done), 64'(0));
    idle(2);

    // Three back-to-back requests, third held off while the queue is full
    rec_on = 1;
    step(1'b1, 2'd0, 2'd3, $urandom());
    step(1'b1, 2'd1, 2'd2, $urandom());
    chk("t035_ready_full", 64'(ready), 64'(0));
    step(1'b1, 2'd3, 2'd0, $urandom());
    step(1'b1, 2'd3, 2'd0, $urandom());
    idle(12);
    rec_on = 0;
    chk("t035_ld_count", 64'(ldseq.size()), 64'(3));
    chk("t035_done_count", 64'(dedges.size()), 64'(3));
    if (ldseq.size() == 3) begin
      chk("t035_ld0", 64'(ldseq[0]), 64'(4'b1000));
      chk("t035_ld1", 64'(ldseq[1]), 64'(4'b0100));
      chk("t035_ld2", 64'(ldseq[2]), 64'(4'b0001));
    end
    if (dedges.size() == 3) begin
      chk("t035_gap0", 64'(dedges[1] - dedges[0]), 64'(4));
      chk("t035_gap1", 64'(dedges[2] - dedges[1]), 64'(4));
    end

    // Self transfer 1 -> 1
    k = done_total;
    step(1'b1, 2'd1, 2'd1, $urandom());
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 2'd0, 2'd0, $urandom());
      chk("t036_ld", 64'(ld), 64'(0));
      if (done === 1'b1) chk("t036_nop", 64'(nop), 64'(1));
    end
    chk("t036_dones", 64'(done_total - k), 64'(1));

    // Reset while in LOAD with two entries queued
    step(1'b1, 2'd0, 2'd2, $urandom());
    step(1'b1, 2'd1, 2'd3, $urandom());
    step(1'b1, 2'd2, 2'd0, $urandom());
    step(1'b1, 2'd2, 2'd0, $urandom());
    chk("t037_ld_before", 64'(ld), 64'(4'b0100));
    do_reset();
    k = done_total;
    idle(10);
    chk("t037_no_done", 64'(done_total - k), 64'(0));
    chk("t037_cnt", 64'(xfer_cnt), 64'(0));
    chk("t037_ready", 64'(ready), 64'(1));

    rand_traffic(300);
    idle(16);

    // Counter wrap after 256 completions
    do_reset();
    done_total = 0;
    k = 0;
    while (done_total < 256 && k < 1500) begin
      step(1'b1, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), $urandom());
      k++;
      if (done === 1'b1 && done_total == 255) chk("t038_cnt255", 64'(xfer_cnt), 64'(255));
      if (done === 1'b1 && done_total == 256) chk("t038_wrap", 64'(xfer_cnt), 64'(0));
    end
    chk("t038_done_total", 64'(done_total), 64'(256));
    idle(12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
